spi_write_tx: RTL



---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_clk_div.sv | 39 +++
 rtl/spi_write_tx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared SPI types and constants (FSM states, mode, defaults).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } spi_state_e;

    localparam logic c_CPOL        = 1'b0;
    localparam logic c_CPHA        = 1'b0;
    localparam int   c_DEF_WIDTH   = 16;
    localparam int   c_DEF_CLK_DIV = 4;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_clk_div.sv
// ============================================================================
// Module   : spi_clk_div
// Brief    : ClkDiv-cycle tick generator with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_clk_div
    import spi_pkg::*;
#(
    parameter int ClkDiv = c_DEF_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int              c_CW   = cnt_width(ClkDiv);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(ClkDiv - 1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    // Clear suppresses the tick so a phase always lasts a full ClkDiv cycles.
    assign tick_o = !clr_i && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/spi_write_tx.sv
// ============================================================================
// Module   : spi_write_tx
// Brief    : SPI mode-0 master transmitter with CS framing and SCLK divider.
//            Define SPI_WRITE_LSB_FIRST_EN to transmit din[0] first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_write_tx
    import spi_pkg::*;
#(
    parameter int Width  = c_DEF_WIDTH,
    parameter int ClkDiv = c_DEF_CLK_DIV
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [Width-1:0] din_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             cs_o,
    output logic             sclk_o,
    output logic             mosi_o
);

    localparam int              c_BW   = $clog2(Width + 1);
    localparam logic [c_BW-1:0] c_BITS = c_BW'(Width);

    spi_state_e       r_state;
    logic [Width-1:0] r_shreg;
    logic [c_BW-1:0]  r_bitcnt;
    logic             r_cs;
    logic             r_sclk;
    logic             r_mosi;
    logic             r_busy;
    logic             r_done;

    logic             w_tick;
    logic             w_clr;
    logic [Width-1:0] w_shifted;
    logic             w_first_bit;
    logic             w_next_bit;

    assign w_clr = (r_state == ST_IDLE);

    spi_clk_div #(
        .ClkDiv (ClkDiv)
    ) u_clk_div (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (w_clr),
        .tick_o (w_tick)
    );

`ifdef SPI_WRITE_LSB_FIRST_EN
    assign w_shifted   = r_shreg >> 1;
    assign w_first_bit = din_i[0];
    assign w_next_bit  = r_shreg[1];
`else
    assign w_shifted   = r_shreg << 1;
    assign w_first_bit = din_i[Width-1];
    assign w_next_bit  = r_shreg[Width-2];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_cs     <= 1'b1;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_shreg  <= din_i;
                        r_bitcnt <= '0;
                        r_mosi   <= w_first_bit;
                        r_cs     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_tick) begin
                        r_sclk  <= 1'b1;
                        r_state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    // MOSI moves only on the falling edge, giving full setup/hold.
                    if (w_tick) begin
                        r_sclk   <= 1'b0;
                        r_shreg  <= w_shifted;
                        r_mosi   <= w_next_bit;
                        r_bitcnt <= r_bitcnt + c_BW'(1);
                        r_state  <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (w_tick) begin
                        if (r_bitcnt < c_BITS) begin
                            r_sclk  <= 1'b1;
                            r_state <= ST_HIGH;
                        end else begin
                            r_cs    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_mosi  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign cs_o   = r_cs;
    assign sclk_o = r_sclk;
    assign mosi_o = r_mosi;

endmodule

`default_nettype wire
